clks_alot_generator: RTL and testbench

- Transmit-side counterpart of the clks_alot recovery path.
- Synthesises a programmable-duty output clock from the system domain.
- Emits per-cycle edge event pulses in the shared clks_alot_p::generated_events_s format:
  - expected events, aligned with each output edge;
  - preemptive events, one cycle before each edge.
- Downstream logic and the recovery side's comparison logic consume the same event encoding.
- High/low phase lengths are loaded through a valid/ready config handshake while idle.

---
 rtl/clks_alot_p.sv | 16 +
 rtl/common_p.sv | 9 +
 rtl/clks_alot_generator.sv | 116 +++++++++++
 tb/tb_clks_alot_generator.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/clks_alot_p.sv
// rtl/clks_alot_p.sv - event and status encodings shared by the clks_alot generator and recovery paths
package clks_alot_p;

  typedef struct packed {
    logic rising;
    logic falling;
    logic any;
  } generated_events_s;

  typedef struct packed {
    logic running;
    logic configured;
    logic config_error;
  } clock_status_s;

endpackage

// File: rtl/common_p.sv
// rtl/common_p.sv - shared clock-domain bundle type
package common_p;

  typedef struct packed {
    logic clk;
    logic sync_rst;
  } clk_dom_s;

endpackage

// File: rtl/clks_alot_generator.sv
// rtl/clks_alot_generator.sv - programmable-duty clock generator with aligned and one-cycle-early edge events
module clks_alot_generator #(
  parameter int COUNT_WIDTH = 16
) (
  input  common_p::clk_dom_s             sys_dom_i,
  input  logic                           config_valid_i,
  output logic                           config_ready_o,
  input  logic [COUNT_WIDTH-1:0]         config_high_count_i,
  input  logic [COUNT_WIDTH-1:0]         config_low_count_i,
  input  logic                           enable_i,
  output logic                           clk_o,
  output clks_alot_p::generated_events_s expected_clks_o,
  output clks_alot_p::generated_events_s preemetive_clks_o,
  output clks_alot_p::clock_status_s     gen_status_o
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_e;

  localparam logic [COUNT_WIDTH-1:0] ONE       = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] MIN_COUNT = COUNT_WIDTH'(2);

  state_e                         state;
  logic [COUNT_WIDTH-1:0]         cnt;
  logic [COUNT_WIDTH-1:0]         high_count;
  logic [COUNT_WIDTH-1:0]         low_count;
  logic                           clk_q;
  logic                           ready_q;
  clks_alot_p::generated_events_s expected_q;
  clks_alot_p::generated_events_s preemptive_q;
  clks_alot_p::clock_status_s     status_q;

  logic cfg_xfer;
  logic cfg_bad;

  assign cfg_xfer = config_valid_i & ready_q;
  assign cfg_bad  = (config_high_count_i < MIN_COUNT) | (config_low_count_i < MIN_COUNT);

  // The FSM runs one cycle ahead of clk_o: a state change raises the
  // preemptive event, and clk_o/expected follow from it on the next edge.
  always_ff @(posedge sys_dom_i.clk) begin
    if (sys_dom_i.sync_rst) begin
      state        <= IDLE;
      cnt          <= '0;
      high_count   <= '0;
      low_count    <= '0;
      clk_q        <= 1'b0;
      ready_q      <= 1'b1;
      expected_q   <= '0;
      preemptive_q <= '0;
      status_q     <= '0;
    end else begin
      clk_q        <= (state == HIGH);
      expected_q   <= preemptive_q;
      preemptive_q <= '0;

      if (cfg_xfer) begin
        if (cfg_bad) begin
          status_q.config_error <= 1'b1;
        end else begin
          high_count            <= config_high_count_i;
          low_count             <= config_low_count_i;
          status_q.configured   <= 1'b1;
          status_q.config_error <= 1'b0;
        end
      end

      case (state)
        IDLE: begin
          if (enable_i && status_q.configured && !cfg_xfer) begin
            preemptive_q.rising <= 1'b1;
            preemptive_q.any    <= 1'b1;
            state               <= HIGH;
            cnt                 <= high_count - ONE;
            ready_q             <= 1'b0;
            status_q.running    <= 1'b1;
          end
        end
        HIGH: begin
          if (cnt == '0) begin
            preemptive_q.falling <= 1'b1;
            preemptive_q.any     <= 1'b1;
            state                <= LOW;
            cnt                  <= low_count - ONE;
          end else begin
            cnt <= cnt - ONE;
          end
        end
        LOW: begin
          if (cnt == '0) begin
            // enable_i only matters here, so a period is never cut short
            if (enable_i) begin
              preemptive_q.rising <= 1'b1;
              preemptive_q.any    <= 1'b1;
              state               <= HIGH;
              cnt                 <= high_count - ONE;
            end else begin
              state            <= IDLE;
              ready_q          <= 1'b1;
              status_q.running <= 1'b0;
            end
          end else begin
            cnt <= cnt - ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign clk_o             = clk_q;
  assign config_ready_o    = ready_q;
  assign expected_clks_o   = expected_q;
  assign preemetive_clks_o = preemptive_q;
  assign gen_status_o      = status_q;

endmodule

// File: tb/tb_clks_alot_generator.sv
// tb/tb_clks_alot_generator.sv - scoreboard bench for clks_alot_generator
module tb_clks_alot_generator;

  localparam int CW = 16;

  logic                           clk = 1'b0;
  logic                           rst;
  common_p::clk_dom_s             sys_dom;
  logic                           config_valid;
  logic                           config_ready;
  logic [CW-1:0]                  high_cnt;
  logic [CW-1:0]                  low_cnt;
  logic                           enable;
  logic                           gen_clk;
  clks_alot_p::generated_events_s exp_ev;
  clks_alot_p::generated_events_s pre_ev;
  clks_alot_p::clock_status_s     status;

  assign sys_dom = '{clk: clk, sync_rst: rst};

  clks_alot_generator #(.COUNT_WIDTH(CW)) dut (
    .sys_dom_i           (sys_dom),
    .config_valid_i      (config_valid),
    .config_ready_o      (config_ready),
    .config_high_count_i (high_cnt),
    .config_low_count_i  (low_cnt),
    .enable_i            (enable),
    .clk_o               (gen_clk),
    .expected_clks_o     (exp_ev),
    .preemetive_clks_o   (pre_ev),
    .gen_status_o        (status)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    logic [10:0] v;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic done   = 1'b0;

  // {clk, exp r/f/any, pre r/f/any, running, configured, config_error, ready}
  function automatic logic [10:0] vec(logic c, logic er, logic ef, logic pr, logic pf,
                                      logic run, logic cfgd, logic err);
    return {c, er, ef, er | ef, pr, pf, pr | pf, run, cfgd, err, ~run};
  endfunction

  wire [10:0] got = {gen_clk, exp_ev.rising, exp_ev.falling, exp_ev.any,
                     pre_ev.rising, pre_ev.falling, pre_ev.any,
                     status.running, status.configured, status.config_error, config_ready};

  always @(negedge clk) begin : monitor
    exp_t e;
    while (sb.size() > 0 && (sb[0].at <= cyc || done)) begin
      e = sb.pop_front();
      checks++;
      if (e.at != cyc || got !== e.v) begin
        errors++;
        $display("FAIL %s cyc=%0d due=%0d: got %b want %b", e.name, cyc, e.at, got, e.v);
      end
    end
  end

  task automatic push(int at, logic [10:0] v, string name);
    exp_t e;
    e.at = at; e.v = v; e.name = name;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(int c);
    while (cyc < c) tick();
  endtask

  task automatic push_idle(int from, int n, logic cfgd, logic err, string name);
    for (int i = 0; i < n; i++) push(from + i, vec(0, 0, 0, 0, 0, 0, cfgd, err), name);
  endtask

  // Hand rule for a running generator, t = offset into the H+L period from c0
  task automatic push_run(int c0, int h, int l, int n, logic err, string name);
    for (int i = 0; i < n; i++) begin
      int t;
      t = i % (h + l);
      push(c0 + i, vec(t >= 1 && t <= h, t == 1, t == h + 1, t == 0, t == h, 1, 1, err), name);
    end
  endtask

  task automatic do_cfg(int h, int l, logic cfgd, logic err, string name);
    int m;
    m = cyc;
    config_valid = 1'b1;
    high_cnt = CW'(h);
    low_cnt  = CW'(l);
    push(m + 1, vec(0, 0, 0, 0, 0, 0, cfgd, err), name);
    tick();
    config_valid = 1'b0;
  endtask

  task automatic do_run(int h, int l, int periods, int drop_off, logic err, string name);
    int c0;
    int p;
    c0 = cyc + 1;
    p  = h + l;
    enable = 1'b1;
    push_run(c0, h, l, periods * p, err, name);
    push_idle(c0 + periods * p, 2, 1, err, {name, "_end"});
    wait_until(c0 + (periods - 1) * p + drop_off);
    enable = 1'b0;
    wait_until(c0 + periods * p + 2);
  endtask

  initial begin : stimulus
    int c0;
    int m;
    rst = 1'b1;
    enable = 1'b1;
    config_valid = 1'b0;
    high_cnt = '0;
    low_cnt = '0;

    push_idle(1, 22, 0, 0, "reset_idle");
    tick();
    tick();
    rst = 1'b0;
    wait_until(22);
    enable = 1'b0;

    do_cfg(3, 2, 1, 0, "cfg_3_2");
    do_run(3, 2, 10, 0, 0, "run_3_2");

    do_cfg(1, 5, 1, 1, "cfg_bad");
    do_run(3, 2, 1, 0, 1, "run_after_bad");

    do_cfg(2, 2, 1, 0, "cfg_2_2");
    do_run(2, 2, 3, 0, 0, "run_2_2");

    do_cfg(4, 4, 1, 0, "cfg_4_4");
    do_run(4, 4, 1, 2, 0, "drop_mid_high");

    // config held valid through a run is accepted only once idle
    c0 = cyc + 1;
    enable = 1'b1;
    push_run(c0, 4, 4, 8, 0, "held_cfg_run");
    push_idle(c0 + 8, 2, 1, 0, "held_cfg_idle");
    wait_until(c0 + 2);
    config_valid = 1'b1;
    high_cnt = CW'(3);
    low_cnt  = CW'(2);
    wait_until(c0 + 5);
    enable = 1'b0;
    wait_until(c0 + 9);
    config_valid = 1'b0;
    wait_until(c0 + 10);
    do_run(3, 2, 1, 0, 0, "run_after_held");

    // config and enable together: start deferred, new counts used
    m = cyc;
    enable = 1'b1;
    config_valid = 1'b1;
    high_cnt = CW'(2);
    low_cnt  = CW'(3);
    push(m + 1, vec(0, 0, 0, 0, 0, 0, 1, 0), "same_cycle_defer");
    tick();
    config_valid = 1'b0;
    c0 = m + 2;
    push_run(c0, 2, 3, 5, 0, "same_cycle_run");
    push_idle(c0 + 5, 1, 1, 0, "same_cycle_end");
    wait_until(c0 + 1);
    enable = 1'b0;
    wait_until(c0 + 6);

    // reset in mid-HIGH aborts with no falling event
    do_cfg(8, 3, 1, 0, "cfg_8_3");
    c0 = cyc + 1;
    enable = 1'b1;
    push_run(c0, 8, 3, 4, 0, "pre_abort");
    push_idle(c0 + 4, 9, 0, 0, "post_abort");
    wait_until(c0 + 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if (gen_clk !== 1'b0 || exp_ev !== '0 || pre_ev !== '0 || status.configured !== 1'b0) begin
      errors++;
      $display("FAIL abort_direct: clk=%b exp=%b pre=%b cfgd=%b",
               gen_clk, exp_ev, pre_ev, status.configured);
    end
    wait_until(c0 + 13);
    enable = 1'b0;
    tick();

    done = 1'b1;
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d entries never checked", sb.size());
    end
    if (checks < 12) begin
      errors++;
      $display("FAIL coverage: only %0d checks ran", checks);
    end
    if (errors != 0) $display("FAIL");
    else             $display("PASS");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
